// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared opcode, ALU operation, FSM state and instruction
//               layout definitions for the ALU sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  // Instruction opcodes, bits [15:12]
  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_SHL  = 4'h2;
  localparam logic [3:0] OPC_SHR  = 4'h3;
  localparam logic [3:0] OPC_MOV  = 4'h4;
  localparam logic [3:0] OPC_MOVI = 4'h5;
  localparam logic [3:0] OPC_JMP  = 4'h6;
  localparam logic [3:0] OPC_JZ   = 4'h7;
  localparam logic [3:0] OPC_JC   = 4'h8;
  localparam logic [3:0] OPC_JN   = 4'h9;
  localparam logic [3:0] OPC_HALT = 4'hF;

  // ALU operation codes driven on alu_op
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SHL = 4'h2;
  localparam logic [3:0] ALU_SHR = 4'h3;
  localparam logic [3:0] ALU_MOV = 4'h4;

  // Sequencer FSM state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int NUM_REGS = 4;

  typedef logic [7:0] word_t;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  // Opcodes 0..5 go through the ALU; everything else retires in DECODE
  function automatic logic is_alu_opc(input logic [3:0] opc);
    return (opc <= OPC_MOVI);
  endfunction

  // MOVI reuses the ALU move path with the immediate on operand B
  function automatic logic [3:0] alu_op_of(input logic [3:0] opc);
    return (opc == OPC_MOVI) ? ALU_MOV : opc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Instruction-memory fetch and ALU handshake bundle. The
//               sequencer is the master; memory/ALU side is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;
  logic [3:0]      alu_op;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [7:0]      alu_result;
  logic            alu_zero;
  logic            alu_carry;
  logic            alu_neg;

  modport master (
    output imem_req, imem_addr, alu_op, alu_a, alu_b,
    input  imem_rdata, imem_ack, alu_result, alu_zero, alu_carry, alu_neg
  );

  modport slave (
    input  imem_req, imem_addr, alu_op, alu_a, alu_b,
    output imem_rdata, imem_ack, alu_result, alu_zero, alu_carry, alu_neg
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer_regfile.sv
`default_nettype none
// ============================================================================
// Module      : seq_regfile
// Description : 4x8 register file, one write port, two read ports and a
//               debug read port, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_regfile
  import alu_sequencer_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_we,
  input  wire logic [1:0] i_waddr,
  input  wire word_t      i_wdata,
  input  wire logic [1:0] i_raddr_a,
  input  wire logic [1:0] i_raddr_b,
  input  wire logic [1:0] i_dbg_sel,
  output word_t           o_rdata_a,
  output word_t           o_rdata_b,
  output word_t           o_dbg_val
);

  word_t r_mem [NUM_REGS];

  // Storage: clear on reset, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_dbg_val = r_mem[i_dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Fetch/decode/execute/writeback controller driving an 8-bit
//               ALU. Owns PC, 4x8 register file, latched flags and branches.
//               Optional macro SEQ_TRACE_EN adds a retirement trace port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [3:0] IDLE_OP = 4'b1111
)(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  alu_sequencer_if.master  bus,
  output logic             busy,
  output logic             halted,
  input  wire logic [1:0]  dbg_sel,
  output word_t            dbg_val
`ifdef SEQ_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [PC_W-1:0]  trace_pc,
  output logic [15:0]      trace_instr
`endif
);

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  instr_t          r_instr;
  logic            r_z, r_c, r_n;
  logic            r_req;
  logic [3:0]      r_op;
  word_t           r_a, r_b;
  logic            r_busy, r_halted;

  word_t           w_rd_val, w_rs_val;
  logic            w_we;
  logic            w_taken;
  logic [PC_W-1:0] w_pc_inc, w_target;

  assign w_we     = (r_state == S_WB);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_target = PC_W'(r_instr.imm);

  seq_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (r_instr.rd),
    .i_wdata   (bus.alu_result),
    .i_raddr_a (r_instr.rd),
    .i_raddr_b (r_instr.rs),
    .i_dbg_sel (dbg_sel),
    .o_rdata_a (w_rd_val),
    .o_rdata_b (w_rs_val),
    .o_dbg_val (dbg_val)
  );

  // Branch decision against the flags latched by the last writeback
  always_comb begin
    w_taken = 1'b0;
    case (r_instr.opc)
      OPC_JMP: w_taken = 1'b1;
      OPC_JZ:  w_taken = r_z;
      OPC_JC:  w_taken = r_c;
      OPC_JN:  w_taken = r_n;
      default: w_taken = 1'b0;
    endcase
  end

  // Main sequencer FSM; every bus-facing output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_z      <= 1'b1;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_req    <= 1'b0;
      r_op     <= IDLE_OP;
      r_a      <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          // Restart from HALT keeps registers and flags, only PC rewinds
          if (start) begin
            r_pc     <= '0;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= instr_t'(bus.imem_rdata);
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu_opc(r_instr.opc)) begin
            r_op    <= alu_op_of(r_instr.opc);
            r_a     <= w_rd_val;
            r_b     <= (r_instr.opc == OPC_MOVI) ? r_instr.imm : w_rs_val;
            r_state <= S_EXEC;
          end else if (r_instr.opc == OPC_HALT) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            // Branches and NOPs both retire here; NOPs never take
            r_pc    <= w_taken ? w_target : w_pc_inc;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          r_op    <= IDLE_OP;
          r_state <= S_WB;
        end
        S_WB: begin
          r_z <= bus.alu_zero;
          r_c <= bus.alu_carry;
          // The ALU only refreshes its negative flag on subtraction
          if (r_instr.opc == OPC_SUB) r_n <= bus.alu_neg;
          r_pc    <= w_pc_inc;
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end
        default: begin
          r_req    <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_pc;
  assign bus.alu_op    = r_op;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign busy          = r_busy;
  assign halted        = r_halted;

`ifdef SEQ_TRACE_EN
  logic            r_tr_valid;
  logic [PC_W-1:0] r_tr_pc;
  logic [15:0]     r_tr_instr;

  // Retirement trace: capture at fetch, pulse in DECODE or WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tr_valid <= 1'b0;
      r_tr_pc    <= '0;
      r_tr_instr <= '0;
    end else begin
      r_tr_valid <= 1'b0;
      if (r_state == S_FETCH && bus.imem_ack) begin
        r_tr_pc    <= r_pc;
        r_tr_instr <= bus.imem_rdata;
        r_tr_valid <= !is_alu_opc(bus.imem_rdata[15:12]);
      end else if (r_state == S_EXEC) begin
        r_tr_valid <= 1'b1;
      end
    end
  end

  assign trace_valid = r_tr_valid;
  assign trace_pc    = r_tr_pc;
  assign trace_instr = r_tr_instr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer: directed programs plus
//               random forward-branching programs against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_val;
`ifdef SEQ_TRACE_EN
  logic       trace_valid;
  logic [7:0] trace_pc;
  logic [15:0] trace_instr;
`endif

  alu_sequencer_if #(.PC_W(8)) bus ();

  alu_sequencer #(.PC_W(8), .IDLE_OP(4'hF)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
`ifdef SEQ_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_instr (trace_instr)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] mem [256];
  int          ack_delay = 0;
  logic [7:0]  fetch_log [$];
  logic [7:0]  trace_log [$];
  logic [7:0]  exp_pcs [$];
  int          add_cycles = 0;

  // Architectural model state
  logic [7:0] m_r [4];
  bit         m_z, m_c, m_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int opc, input int rd, input int rs, input int imm);
    return {opc[3:0], rd[1:0], rs[1:0], imm[7:0]};
  endfunction

  // ALU behaviour: {carry, result}
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {(a < b), 8'(a - b)};
      4'd2:    return {a[7], 8'(a << 1)};
      4'd3:    return {a[0], 8'(a >> 1)};
      4'd4:    return {1'b0, b};
      default: return 9'd0;
    endcase
  endfunction

  // Instruction memory responder with a programmable wait count
  initial begin
    int wcnt;
    wcnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (wcnt >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          fetch_log.push_back(bus.imem_addr);
        end else begin
          bus.imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ALU stand-in: result and flags follow any non-idle operation
  initial begin
    logic [8:0] v;
    bus.alu_result = 8'h0;
    bus.alu_zero   = 1'b0;
    bus.alu_carry  = 1'b0;
    bus.alu_neg    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.alu_op == 4'h0) add_cycles++;
      if (bus.alu_op != 4'hF) begin
        v = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_result = v[7:0];
        bus.alu_carry  = v[8];
        bus.alu_zero   = (v[7:0] == 8'h0);
        bus.alu_neg    = v[7];
      end
    end
  end

`ifdef SEQ_TRACE_EN
  initial begin
    forever begin
      @(negedge clk);
      if (trace_valid) trace_log.push_back(trace_pc);
    end
  end
`endif

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h0;
    m_z = 1'b1;
    m_c = 1'b0;
    m_n = 1'b0;
  endtask

  // Instruction-set interpreter: expected fetch order, cycle count, ADD count
  task automatic run_model(input int d, output int cyc, output int adds);
    logic [7:0]  pc, a, b;
    logic [15:0] ins;
    logic [3:0]  opc;
    logic [8:0]  v;
    bit          take;
    exp_pcs.delete();
    pc = 8'h0; cyc = 0; adds = 0;
    for (int s = 0; s < 300; s++) begin
      ins = mem[pc];
      opc = ins[15:12];
      exp_pcs.push_back(pc);
      cyc += d + 1;
      if (opc <= 4'd5) begin
        a = m_r[ins[11:10]];
        b = (opc == 4'd5) ? ins[7:0] : m_r[ins[9:8]];
        v = alu_f((opc == 4'd5) ? 4'd4 : opc, a, b);
        m_r[ins[11:10]] = v[7:0];
        m_z = (v[7:0] == 8'h0);
        m_c = v[8];
        if (opc == 4'd1) m_n = v[7];
        if (opc == 4'd0) adds++;
        cyc += 3;
        pc = pc + 8'd1;
      end else begin
        cyc += 1;
        if (opc == 4'hF) break;
        take = (opc == 4'd6) || (opc == 4'd7 && m_z) || (opc == 4'd8 && m_c) || (opc == 4'd9 && m_n);
        pc = take ? ins[7:0] : pc + 8'd1;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0];
      #1;
      chk(tag, dbg_val, m_r[i]);
    end
  endtask

  // Run the program in mem from PC 0 and compare against the model
  task automatic run_program(input string tag, input int d, input bit extra_start, input bit chk_stall);
    int exp_cyc, exp_adds, cyc, n;
    ack_delay = d;
    run_model(d, exp_cyc, exp_adds);
    @(negedge clk);
    fetch_log.delete();
    trace_log.delete();
    add_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!halted && cyc < 3000) begin
      if (chk_stall && cyc <= d) begin
        chk({tag, ".stall_req"}, bus.imem_req, 1'b1);
        chk({tag, ".stall_addr"}, bus.imem_addr, 8'h00);
        chk({tag, ".stall_op"}, bus.alu_op, 4'hF);
      end
      start = extra_start && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".cycles"}, cyc, exp_cyc + 1);
    chk({tag, ".halted"}, halted, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".add_cycles"}, add_cycles, exp_adds);
    chk({tag, ".fetch_count"}, fetch_log.size(), exp_pcs.size());
    n = (fetch_log.size() < exp_pcs.size()) ? fetch_log.size() : exp_pcs.size();
    for (int i = 0; i < n; i++) chk({tag, ".fetch_pc"}, fetch_log[i], exp_pcs[i]);
`ifdef SEQ_TRACE_EN
    chk({tag, ".trace_count"}, trace_log.size(), exp_pcs.size());
    n = (trace_log.size() < exp_pcs.size()) ? trace_log.size() : exp_pcs.size();
    for (int i = 0; i < n; i++) chk({tag, ".trace_pc"}, trace_log[i], exp_pcs[i]);
`endif
    check_regs({tag, ".reg"});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req"}, bus.imem_req, 1'b0);
    chk({tag, ".addr"}, bus.imem_addr, 8'h00);
    chk({tag, ".op"}, bus.alu_op, 4'hF);
    chk({tag, ".a"}, bus.alu_a, 8'h00);
    chk({tag, ".b"}, bus.alu_b, 8'h00);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".halted"}, halted, 1'b0);
  endtask

  task automatic load_prog1();
    mem[0] = enc(5, 0, 0, 5);
    mem[1] = enc(5, 1, 0, 3);
    mem[2] = enc(0, 0, 1, 0);
    mem[3] = enc(15, 0, 0, 0);
  endtask

  initial begin
    int cyc, n, d;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    rst = 1'b1;
    start = 1'b0;
    dbg_sel = 2'd0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    check_regs("reset.reg");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // MOVI/MOVI/ADD/HALT, zero-wait memory
    load_prog1();
    run_program("add", 0, 1'b0, 1'b0);

    // Subtract to negative with borrow, then JN and JC taken
    mem[0]    = enc(5, 0, 0, 2);
    mem[1]    = enc(5, 1, 0, 3);
    mem[2]    = enc(1, 0, 1, 0);
    mem[3]    = enc(9, 0, 0, 8'h10);
    mem[8'h10] = enc(8, 0, 0, 8'h12);
    mem[8'h11] = enc(15, 0, 0, 0);
    mem[8'h12] = enc(15, 0, 0, 0);
    run_program("sub", 0, 1'b0, 1'b0);

    // JZ taken on zero move, then not taken after nonzero ADD
    mem[0]     = enc(5, 0, 0, 0);
    mem[1]     = enc(4, 1, 0, 0);
    mem[2]     = enc(7, 0, 0, 8'h20);
    mem[8'h20] = enc(5, 2, 0, 1);
    mem[8'h21] = enc(0, 3, 2, 0);
    mem[8'h22] = enc(7, 0, 0, 8'h30);
    mem[8'h23] = enc(15, 0, 0, 0);
    run_program("jz", 1, 1'b0, 1'b0);

    // Four-cycle fetch stall
    load_prog1();
    run_program("stall", 4, 1'b0, 1'b1);

    // Reset in the middle of the ADD execute cycle
    load_prog1();
    ack_delay = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (bus.alu_op !== 4'h0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_exec.reached", bus.alu_op, 4'h0);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst_exec");
    check_regs("rst_exec.reg");
    @(negedge clk);
    rst = 1'b0;

    // PC wrap: JZ to 0xFE, NOP at 0xFF, fetch wraps to 0x00
    mem[0]     = enc(7, 0, 0, 8'hFE);
    mem[1]     = enc(15, 0, 0, 0);
    mem[8'hFE] = enc(5, 0, 0, 1);
    mem[8'hFF] = enc(10, 0, 0, 0);
    run_program("wrap", 0, 1'b0, 1'b0);

    // Random forward-branching programs, restart ignored while busy
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
      n = 12;
      for (int pc = 0; pc < n; pc++) begin
        int opc;
        opc = $urandom_range(0, 14);
        if (opc >= 6 && opc <= 9)
          mem[pc] = enc(opc, 0, 0, $urandom_range(pc + 1, n));
        else
          mem[pc] = enc(opc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
      end
      d = $urandom_range(0, 3);
      run_program("random", d, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback controller that drives the 8-bit ALU. It is the initiator side of the ALU interface: it presents op/operands, consumes result and flags, and owns the PC, a 4x8 register file and branch decisions. It sits between instruction memory and the ALU in the processor top level.

Parameters:
PC_W, 8, program counter and instruction address width
IDLE_OP, 4'b1111, ALU op driven when not executing (ALU default case, holds result/flags)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or HALT
imem_req  out  1  fetch request, held until acknowledged
imem_addr  out  PC_W  fetch address (= PC)
imem_rdata  in  16  instruction, valid in the imem_ack cycle
imem_ack  in  1  fetch acknowledge
alu_op  out  4  ALU operation code
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_result  in  8  ALU result
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag
alu_neg  in  1  ALU negative flag
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
dbg_sel  in  2  register-file read select
dbg_val  out  8  register-file contents at dbg_sel (combinational)

Behaviour:
- Instruction: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes: 0 ADD rd=rd+rs; 1 SUB rd=rd-rs; 2 SHL rd=rd<<1; 3 SHR rd=rd>>1; 4 MOV rd=rs; 5 MOVI rd=imm (via ALU op 4, alu_b=imm); 6 JMP; 7 JZ; 8 JC; 9 JN; F HALT; others are NOP (PC+1).
- Reset: state IDLE, PC=0, regs=0, latched flags Z=1/C=0/N=0, alu_op=IDLE_OP, alu_a=alu_b=0, imem_req=0, busy=0, halted=0.
- All outputs registered except dbg_val.
- IDLE: wait for start -> FETCH.
- FETCH: imem_req=1, imem_addr=PC. Stalls indefinitely without ack. On imem_ack, latch instruction, drop req -> DECODE.
- DECODE:
  - ALU opcodes (0-5): drive alu_op (0..4), alu_a=R[rd], alu_b=R[rs] or imm -> EXEC.
  - Branches: JMP always; JZ/JC/JN test latched flags. Taken: PC=imm[PC_W-1:0]; else PC=PC+1. Then -> FETCH.
  - HALT -> HALT.
  - NOP: PC+1 -> FETCH.
- EXEC: alu_op/operands stable for this whole cycle; the ALU captures at the closing edge. On that edge alu_op returns to IDLE_OP -> WB.
- WB: R[rd]=alu_result; latch Z/C/N from ALU flags; PC=PC+1 -> FETCH. N is latched only for SUB; other ops retain the previous N (ALU does not update it).
- Latency: ALU instruction = fetch cycles + 3 (DECODE, EXEC, WB); branch/NOP = fetch + 1.
- PC wraps from 2^PC_W-1 to 0 without error.
- start while busy is ignored. start in HALT: PC=0, regs and flags retained -> FETCH.
- rst at any point, including during FETCH with req outstanding or during EXEC: immediate return to reset values. A late imem_ack is ignored in IDLE.
- Simultaneous imem_ack and rst: rst wins.

Optional Feature:
SEQ_TRACE_EN: adds outputs trace_valid (1), trace_pc (PC_W) and trace_instr (16). trace_valid pulses one cycle per retired instruction: the WB cycle for ALU ops, the DECODE cycle for branch/NOP/HALT. trace_pc and trace_instr hold the retiring instruction's PC and encoding. Without the macro these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header: opcode constants, ALU op codes (ADD=0 .. MOV=4, IDLE_OP), state encodings, instruction field positions.
- Sub-module seq_regfile: 4x8, one write port, two read ports plus debug read port, async reset.

Test Plan:
- Program MOVI R0,5; MOVI R1,3; ADD R0,R1; HALT with 0-wait memory -> R0=8, Z=0, C=0, halted=1. Each ADD's alu_op=0 lasts exactly one cycle.
- MOVI R0,2; MOVI R1,3; SUB R0,R1 -> R0=8'hFF, N=1, C=1. A following JN 8'h10 -> next imem_addr=8'h10.
- MOVI R0,0; MOV R1,R0; JZ 8'h20 -> taken (Z=1). After ADD giving 8'h01, JZ -> not taken, PC+1.
- imem_ack delayed 4 cycles -> imem_req and imem_addr held stable for all 4 cycles, state unchanged, alu_op=IDLE_OP.
- rst asserted during EXEC of ADD -> next cycle all outputs at reset values, R[rd] unmodified; later start re-fetches from 0.
- With PC_W=8, NOP at 8'hFF -> next fetch addr 8'h00. Under SEQ_TRACE_EN, trace_pc=8'hFF pulses once.
